present_round_ctrl: RTL and testbench

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

---
 rtl/present_round_ctrl.sv | 152 +++++++++++++++
 tb/tb_present_round_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/present_round_ctrl.sv
// PRESENT-80 iterative encryption core: one round per clock, valid/ready on both sides.
// Holds the S-box, the substitution/permutation layer and the round controller FSM.

module present_sbox (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'h0;
    case (x_i)
      4'h0: y_o = 4'hC;
      4'h1: y_o = 4'h5;
      4'h2: y_o = 4'h6;
      4'h3: y_o = 4'hB;
      4'h4: y_o = 4'h9;
      4'h5: y_o = 4'h0;
      4'h6: y_o = 4'hA;
      4'h7: y_o = 4'hD;
      4'h8: y_o = 4'h3;
      4'h9: y_o = 4'hE;
      4'hA: y_o = 4'hF;
      4'hB: y_o = 4'h8;
      4'hC: y_o = 4'h4;
      4'hD: y_o = 4'h7;
      4'hE: y_o = 4'h1;
      4'hF: y_o = 4'h2;
      default: y_o = 4'h0;
    endcase
  end
endmodule

// sBoxLayer followed by pLayer (bit i -> i*16 mod 63, bit 63 fixed).
module present_sub_per #(
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 4
) (
  input  logic [NUM_LANES*VEC_W-1:0] d_i,
  output logic [NUM_LANES*VEC_W-1:0] q_o
);
  localparam int W = NUM_LANES * VEC_W;

  logic [NUM_LANES-1:0][VEC_W-1:0] sb_in, sb_out;
  assign sb_in = d_i;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    present_sbox u_sbox (.x_i(sb_in[l]), .y_o(sb_out[l]));
  end

  for (genvar i = 0; i < W; i++) begin : g_perm
    localparam int P = (i == W-1) ? (W-1) : ((i * NUM_LANES) % (W-1));
    assign q_o[P] = sb_out[i / VEC_W][i % VEC_W];
  end
endmodule

module present_round_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] plaintext_i,
  input  logic [79:0] key_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] ciphertext_o,
  output logic [4:0]  round_o
);
  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] ct_q, ct_d;
  logic        out_valid_q, out_valid_d;

  logic [63:0] sp_out;
  logic [79:0] key_rot, key_nxt;
  logic [3:0]  key_sb;

  present_sub_per u_sub_per (.d_i(state_q ^ key_q[79:16]), .q_o(sp_out));

  assign key_rot = {key_q[18:0], key_q[79:19]};
  present_sbox u_key_sbox (.x_i(key_rot[79:76]), .y_o(key_sb));
  assign key_nxt = {key_sb, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    round_d     = round_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = plaintext_i;
          key_d   = key_i;
          round_d = 5'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = sp_out;
        key_d   = key_nxt;
        if (round_q == LAST_RND) begin
          // final whitening with K32; counter parks at LAST_RND
          ct_d  = sp_out ^ key_nxt[79:16];
          fsm_d = DONE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      DONE: begin
        // output register stage: valid rises one cycle after the last round
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o   = (fsm_q == IDLE);
  assign out_valid_o  = out_valid_q;
  assign ciphertext_o = ct_q;
  assign round_o      = round_q;
endmodule

// File: tb/tb_present_round_ctrl.sv
// Scoreboarded bench for present_round_ctrl: known answers, stall, mid-run reset, back-to-back.
module tb_present_round_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [63:0] plaintext_i;
  logic [79:0] key_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] ciphertext_o;
  logic [4:0]  round_o;

  present_round_ctrl #(.ROUNDS(31)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .plaintext_i(plaintext_i), .key_i(key_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ciphertext_o(ciphertext_o), .round_o(round_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  logic [63:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, t;
    logic [79:0] kk;
    logic [4:0]  rc;
    s = pt; kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int j = 0; j < 16; j++) t[4*j +: 4] = SB[s[4*j +: 4]];
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = SB[kk[79:76]];
      rc = 5'(r);
      kk[19:15] = kk[19:15] ^ rc;
    end
    return s ^ kk[79:16];
  endfunction

  // Output-side scoreboard: compare every completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else chk("ct", ciphertext_o, sb_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp,
                      input bit push);
    int w = 0;
    @(negedge clk);
    while (!in_ready_o && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b1; plaintext_i = pt; key_i = k;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid_o) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 300) begin @(posedge clk); w++; end
    chk("drain", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, w, acc0, acc1, acc2;
    bit seen;
    logic [63:0] p;
    logic [79:0] k;
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    plaintext_i = '0; key_i = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ct", ciphertext_o, 64'd0);
    chk("rst_round", 64'(round_o), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Known answer, latency and handshake turnaround
    send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b1);
    wait_out(lat);
    chk("latency", 64'(lat), 64'd32);
    chk("in_ready_in_done", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("out_valid_drop", 64'(out_valid_o), 64'd0);
    chk("in_ready_back", 64'(in_ready_o), 64'd1);

    send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b1);
    drain();
    send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b1);
    drain();

    // Consumer stall: output held, new input ignored
    out_ready_i = 1'b0;
    send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b1);
    wait_out(lat);
    in_valid_i = 1'b1; plaintext_i = 64'h1234; key_i = 80'h5678;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_ct", ciphertext_o, 64'h3333DCD3213210D2);
      chk("stall_valid", 64'(out_valid_o), 64'd1);
      chk("stall_in_ready", 64'(in_ready_o), 64'd0);
    end
    @(negedge clk); in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 64'(out_valid_o), 64'd0);
    drain();

    // Reset at round 15 aborts the block
    send(64'hDEADBEEFCAFEF00D, 80'h0123456789ABCDEF0123, 64'h0, 1'b0);
    w = 0;
    while (round_o != 5'd15 && w < 100) begin @(posedge clk); #1; w++; end
    chk("reach_round15", 64'(round_o), 64'd15);
    #2 rst = 1'b1;
    #1;
    chk("abort_round", 64'(round_o), 64'd0);
    chk("abort_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid_o) seen = 1'b1; end
    chk("abort_no_output", 64'(seen), 64'd0);
    send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b1);
    drain();

    // Back-to-back with in_valid and out_ready held high
    acc0 = 0; acc1 = 0; acc2 = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      p = {$urandom, $urandom};
      k = {16'($urandom), $urandom, $urandom};
      plaintext_i = p; key_i = k;
      w = 0;
      while (!in_ready_o && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) chk("b2b_timeout", 64'd0, 64'd1);
      sb_q.push_back(ref_enc(p, k));
      @(posedge clk); #1;
      if (n == 0) acc0 = cyc; else if (n == 1) acc1 = cyc; else acc2 = cyc;
      if (n == 0) begin
        for (int j = 1; j <= 31; j++) begin
          chk("round_trace", 64'(round_o), 64'(j));
          @(posedge clk); #1;
        end
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    chk("b2b_period1", 64'(acc1 - acc0), 64'd34);
    chk("b2b_period2", 64'(acc2 - acc1), 64'd34);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
